logic_unit_sequencer: RTL and testbench
=======================================

# logic_unit_sequencer

Self-test sequencer for the team's basic two-input logic unit: AND, OR, NOT, XOR and NAND. On `start` it drives all four {a,b} input combinations for each of the five operations into the unit and samples the unit's output after a programmable settle time. It compares each sample against the expected truth table and reports a per-operation pass mask, an error count and the first failing vector. It sits between a bench or BIST controller and the combinational logic unit, owning the unit's inputs for the duration of a run.

## Interface
- `SETTLE_CYCLES`, default 0: extra hold cycles per vector before sampling. Legal range 0..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `y_in`  in  1  logic unit output for the currently driven `op_sel`/`a_out`/`b_out`.
- `a_out`, `b_out`  out  1 each  operand drive to the logic unit.
- `op_sel`  out  3  operation select: 0=AND, 1=OR, 2=NOT(a), 3=XOR, 4=NAND. Values 5..7 are never driven.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass_mask`  out  5  bit k=1 when all four vectors of op k matched.
- `err_count`  out  5  total mismatches, 0..20.
- `fail_op`  out  3  op of first mismatch; meaningful only when `err_count`!=0.
- `fail_ab`  out  2  {a,b} of first mismatch; meaningful only when `err_count`!=0.

## Operation
- States: IDLE, RUN. A vector counter `vec` (0..3, equal to {a,b}), an op counter `op` (0..4) and a settle counter `cnt` (4 bits).
- Vector order: op-major, with op 0..4 outer and {a,b} = 00, 01, 10, 11 inner. 20 vectors total.
- Expected value per op:
  - AND: a&b
  - OR: a|b
  - NOT: ~a, with b still driven per the vector
  - XOR: a^b
  - NAND: ~(a&b)
- IDLE with `start`=1 at an edge:
  - go to RUN;
  - `busy`←1;
  - `a_out`/`b_out`/`op_sel`←0;
  - `cnt`←SETTLE_CYCLES;
  - `pass_mask`←5'b11111, `err_count`←0, `fail_op`←0, `fail_ab`←0.
- RUN edge with `cnt`!=0: `cnt`←`cnt`-1; the drive is held.
- RUN edge with `cnt`==0 (sample edge): compare `y_in` with the expected value.
  - On mismatch: clear `pass_mask[op]` and increment `err_count`.
  - If this is the first mismatch of the run (`err_count` was 0), load `fail_op`←op and `fail_ab`←vec.
  - If not the last vector (op=4, vec=3): advance `vec`; on `vec` wrap, advance `op`. Update the drive and reload `cnt`←SETTLE_CYCLES.
  - If the last vector: go to IDLE; `busy`←0; `done`←1 for one cycle; drive returns to 0.
- `start` while in RUN is ignored; there is no queueing.
- Results (`pass_mask`, `err_count`, `fail_op`, `fail_ab`) hold after `done` until the next accepted `start`.
- `rst_n` low, at any time including mid-run: immediately force IDLE and drive all outputs to 0, including `pass_mask`=0. No partial results are retained.

## Timing
- All outputs are registered.
- Reset values: every output is 0.
- Each vector is driven for exactly SETTLE_CYCLES+1 cycles. `y_in` is sampled at the last edge of that window, so the logic unit has SETTLE_CYCLES+1 cycles minus clock-to-q to settle.
- Latency: accepting `start` at edge E0 puts `done` high after edge E0+20·(SETTLE_CYCLES+1). `busy` is high for 20·(SETTLE_CYCLES+1) cycles.
- `done` and `busy` are never high together.
- Back-to-back runs: `start`=1 during the `done` cycle (state is IDLE) is accepted at that edge. The new run begins with no gap and the results are cleared at that edge.
- No combinational path from any input to any output.

## Test plan
- SETTLE_CYCLES=0, ideal logic unit, `start` pulse → `done` exactly 20 cycles after acceptance; `pass_mask`=11111, `err_count`=0; `a_out`/`b_out` step 00, 01, 10, 11 once per cycle for each op.
- XOR output stuck at 0 → `pass_mask`=10111, `err_count`=2, `fail_op`=3, `fail_ab`=01.
- SETTLE_CYCLES=3, ideal unit, plus a unit whose output is delayed 3 cycles → each vector is held 4 cycles; `done` arrives 80 cycles after start; both units report `pass_mask`=11111.
- `start` re-asserted at vector 5 mid-run → ignored; the run completes normally with one `done` at cycle 20.
- `rst_n` pulsed low at vector 7 → all outputs 0 asynchronously; a fresh `start` then completes with the full correct result.
- `start` held high through the `done` cycle → a second run starts with no gap; results are cleared at that edge; second `done` arrives 20 cycles later.

Source files
------------

// File: rtl/logic_unit_sequencer_if.sv
// Bus between the self-test sequencer, its controller and the logic unit under test.
// The slave modport is the sequencer; the master modport is whoever drives start and y_in.
interface logic_unit_sequencer_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic [2:0] op_sel;
  logic       busy;
  logic       done;
  logic [4:0] pass_mask;
  logic [4:0] err_count;
  logic [2:0] fail_op;
  logic [1:0] fail_ab;

  modport slave (
    input  start, y_in,
    output a_out, b_out, op_sel, busy, done, pass_mask, err_count, fail_op, fail_ab
  );

  modport master (
    output start, y_in,
    input  a_out, b_out, op_sel, busy, done, pass_mask, err_count, fail_op, fail_ab
  );
endinterface

// File: rtl/logic_unit_sequencer.sv
// Walks all {a,b} vectors of AND/OR/NOT/XOR/NAND through the logic unit and scores the replies.
// state  | meaning
// IDLE   | waiting for start, results held
// RUN    | driving vector {op,vec}, cnt counts down the settle window
module logic_unit_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logic_unit_sequencer_if.slave   bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [0:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [2:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [4:0] pass_q, pass_d;
  logic [4:0] err_q, err_d;
  logic [2:0] fail_op_q, fail_op_d;
  logic [1:0] fail_ab_q, fail_ab_d;
  logic       exp_y;

  always_comb begin
    exp_y = 1'b0;
    case (op_q)
      3'd0:    exp_y = vec_q[1] & vec_q[0];
      3'd1:    exp_y = vec_q[1] | vec_q[0];
      3'd2:    exp_y = ~vec_q[1];
      3'd3:    exp_y = vec_q[1] ^ vec_q[0];
      3'd4:    exp_y = ~(vec_q[1] & vec_q[0]);
      default: exp_y = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    fail_op_d = fail_op_q;
    fail_ab_d = fail_ab_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          vec_d     = 2'd0;
          op_d      = 3'd0;
          cnt_d     = SETTLE;
          pass_d    = 5'b11111;
          err_d     = 5'd0;
          fail_op_d = 3'd0;
          fail_ab_d = 2'd0;
        end
      end
      default: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (bus.y_in != exp_y) begin
            pass_d = pass_q & ~(5'b00001 << op_q);
            err_d  = err_q + 5'd1;
            if (err_q == 5'd0) begin
              fail_op_d = op_q;
              fail_ab_d = vec_q;
            end
          end
          if (op_q == 3'd4 && vec_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            vec_d   = 2'd0;
            op_d    = 3'd0;
          end else begin
            vec_d = vec_q + 2'd1;
            if (vec_q == 2'd3) op_d = op_q + 3'd1;
            cnt_d = SETTLE;
          end
        end
      end
    endcase
  end

  // Reset wipes results too: a run interrupted by reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= 2'd0;
      op_q      <= 3'd0;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      pass_q    <= 5'd0;
      err_q     <= 5'd0;
      fail_op_q <= 3'd0;
      fail_ab_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fail_op_q <= fail_op_d;
      fail_ab_q <= fail_ab_d;
    end
  end

  assign bus.a_out     = vec_q[1];
  assign bus.b_out     = vec_q[0];
  assign bus.op_sel    = op_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = done_q;
  assign bus.pass_mask = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_op   = fail_op_q;
  assign bus.fail_ab   = fail_ab_q;
endmodule

// File: tb/tb_logic_unit_sequencer.sv
// Bench: two sequencers (settle 0 and 3), each checked every cycle against a run-offset model.
module tb_logic_unit_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic       start_v [2];
  int         mode_v  [2];   // 0 ideal, 1 XOR stuck at 0, 2 ideal delayed 3 cycles
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       a_v     [2];
  logic [4:0] pm_v    [2];
  logic [4:0] ec_v    [2];
  logic [2:0] fo_v    [2];
  logic [1:0] fa_v    [2];
  int         dcnt_v  [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit ideal(input int o, input int ab);
    logic [3:0] t;
    case (o)
      0:       t = 4'b1000;
      1:       t = 4'b1110;
      2:       t = 4'b0011;
      3:       t = 4'b0110;
      default: t = 4'b0111;
    endcase
    return t[ab];
  endfunction

  function automatic bit unit_reply(input int mode, input int o, input int ab);
    if (mode == 1 && o == 3) return 1'b0;
    return ideal(o, ab);
  endfunction

  // Score the first k vectors of a run against the truth table.
  task automatic score(input int mode, input int k, output int pm, output int ec,
                       output int fo, output int fa);
    pm = 31; ec = 0; fo = 0; fa = 0;
    for (int j = 0; j < k; j++) begin
      if (unit_reply(mode, j / 4, j % 4) != ideal(j / 4, j % 4)) begin
        if (ec == 0) begin fo = j / 4; fa = j % 4; end
        ec++;
        pm = pm & ~(1 << (j / 4));
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S = (g == 0) ? 0 : 3;
    logic_unit_sequencer_if bus ();
    logic [2:0] dly = 3'b000;

    logic_unit_sequencer #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(posedge clk) dly <= {dly[1:0], ideal(bus.op_sel, {bus.a_out, bus.b_out})};

    assign bus.start = start_v[g];
    assign bus.y_in  = (mode_v[g] == 2) ? dly[2]
                     : unit_reply(mode_v[g], bus.op_sel, {bus.a_out, bus.b_out});
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign a_v[g]    = bus.a_out;
    assign pm_v[g]   = bus.pass_mask;
    assign ec_v[g]   = bus.err_count;
    assign fo_v[g]   = bus.fail_op;
    assign fa_v[g]   = bus.fail_ab;

    // Model: n = cycles since the accepting edge; everything else follows from n.
    int n = 0;
    bit mb = 1'b0, md = 1'b0, hr = 1'b0;
    int mode_c = 0;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mb <= 1'b0; md <= 1'b0; hr <= 1'b0; n <= 0;
      end else begin
        md <= 1'b0;
        if (mb) begin
          n <= n + 1;
          if (n + 1 == 20 * (S + 1)) begin mb <= 1'b0; md <= 1'b1; end
        end else if (start_v[g]) begin
          mb <= 1'b1; n <= 0; hr <= 1'b1; mode_c <= mode_v[g];
        end
      end
    end

    always @(negedge clk) begin
      int v, k, pm, ec, fo, fa;
      if (bus.done) dcnt_v[g]++;
      if (chk_en) begin
        v = mb ? n / (S + 1) : 0;
        k = mb ? n / (S + 1) : 20;
        if (hr) score(mode_c, k, pm, ec, fo, fa);
        else begin pm = 0; ec = 0; fo = 0; fa = 0; end
        check($sformatf("s%0d_busy", S), bus.busy, mb);
        check($sformatf("s%0d_done", S), bus.done, md);
        check($sformatf("s%0d_op_sel", S), bus.op_sel, v / 4);
        check($sformatf("s%0d_ab", S), {bus.a_out, bus.b_out}, v % 4);
        check($sformatf("s%0d_pass_mask", S), bus.pass_mask, pm);
        check($sformatf("s%0d_err_count", S), bus.err_count, ec);
        if (ec != 0) begin
          check($sformatf("s%0d_fail_op", S), bus.fail_op, fo);
          check($sformatf("s%0d_fail_ab", S), bus.fail_ab, fa);
        end
      end
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk); start_v[i] = 1'b1;
    @(negedge clk); start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done_v[i] && cyc < limit);
    check("done_seen", done_v[i], 1);
  endtask

  initial begin
    int cyc, d0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    mode_v[0] = 0; mode_v[1] = 0;
    dcnt_v[0] = 0; dcnt_v[1] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy_v[i], 0);
      check("rst_pass_mask", pm_v[i], 0);
      check("rst_err_count", ec_v[i], 0);
      check("rst_fail", {fo_v[i], fa_v[i]}, 0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    pulse_start(0);
    wait_done(0, 100, cyc);
    check("lat_s0", cyc, 20);
    check("ideal_pass_mask", pm_v[0], 5'b11111);
    check("ideal_err_count", ec_v[0], 0);

    mode_v[0] = 1;
    pulse_start(0);
    wait_done(0, 100, cyc);
    check("xor_lat", cyc, 20);
    check("xor_pass_mask", pm_v[0], 5'b10111);
    check("xor_err_count", ec_v[0], 2);
    check("xor_fail_op", fo_v[0], 3);
    check("xor_fail_ab", fa_v[0], 1);
    repeat (3) @(negedge clk);
    check("xor_hold_err", ec_v[0], 2);
    mode_v[0] = 0;

    pulse_start(1);
    wait_done(1, 200, cyc);
    check("lat_s3", cyc, 80);
    check("s3_ideal_pass", pm_v[1], 5'b11111);
    mode_v[1] = 2;
    pulse_start(1);
    wait_done(1, 200, cyc);
    check("lat_s3_delayed", cyc, 80);
    check("s3_delayed_pass", pm_v[1], 5'b11111);
    check("s3_delayed_err", ec_v[1], 0);
    mode_v[1] = 0;

    d0 = dcnt_v[0];
    pulse_start(0);
    repeat (5) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, 100, cyc);
    check("restart_ignored_lat", cyc + 6, 20);
    repeat (25) @(negedge clk);
    check("restart_one_done", dcnt_v[0] - d0, 1);

    pulse_start(0);
    repeat (7) @(negedge clk);
    check("vec7_a", a_v[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy_v[0], 0);
    check("async_a", a_v[0], 0);
    check("async_pass_mask", pm_v[0], 0);
    check("async_err_count", ec_v[0], 0);
    @(negedge clk); rst_n = 1'b1;
    pulse_start(0);
    wait_done(0, 100, cyc);
    check("post_rst_lat", cyc, 20);
    check("post_rst_pass", pm_v[0], 5'b11111);

    mode_v[0] = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk);
    wait_done(0, 100, cyc);
    check("b2b_first_lat", cyc, 20);
    check("b2b_first_err", ec_v[0], 2);
    mode_v[0] = 0;
    @(negedge clk); start_v[0] = 1'b0;
    check("b2b_busy", busy_v[0], 1);
    check("b2b_cleared_err", ec_v[0], 0);
    check("b2b_cleared_pass", pm_v[0], 5'b11111);
    wait_done(0, 100, cyc);
    check("b2b_second_lat", cyc, 20);
    check("b2b_second_pass", pm_v[0], 5'b11111);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
